// File: rtl/jam_pkg.sv
// Shared definitions for the JAM job-assignment search and its cost table.
// Holds the matrix geometry, the cost type and the table FSM encoding.
package jam_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned COST_W = 7;
    localparam int unsigned SUM_W  = 10;
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned ADDR_W = 2 * IDX_W;

    typedef logic [COST_W-1:0] cost_t;
    typedef logic [1:0]        state_t;

    localparam state_t LOAD  = 2'd0;
    localparam state_t DONE  = 2'd1;
    localparam state_t READY = 2'd2;

    function automatic cost_t cost_min(input cost_t a, input cost_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/jam_cost_mem.sv
// N*N x COST_W cost storage: one synchronous write port, one asynchronous read port.
// The array has no reset; validity is tracked by the table FSM.
module jam_cost_mem
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  cost_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output cost_t             rdata
);

    cost_t mem [N*N];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_table.sv
// Cost matrix loader and lookup for JAM: streams in an NxN matrix, computes the
// sum of row minima as a lower bound, and holds JAM in reset until the table is whole.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             reload,
    input  logic             in_valid,
    output logic             in_ready,
    input  cost_t            in_data,
    input  logic [IDX_W-1:0] W,
    input  logic [IDX_W-1:0] J,
    output cost_t            Cost,
    output logic             table_ready,
    output logic             jam_rst,
    output logic [SUM_W-1:0] row_min_sum
);

    state_t            state_q;
    logic [ADDR_W-1:0] k_q;
    cost_t             cur_min_q;
    logic [SUM_W-1:0]  acc_q;
    logic [SUM_W-1:0]  row_min_sum_q;
    logic              table_ready_q;
    logic              jam_rst_q;

    logic  accept;
    logic  we;
    logic  row_last;
    logic  last;
    cost_t min_base;
    cost_t new_min;
    cost_t rdata;

    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid && in_ready;
    assign we       = accept && !reload;
    assign row_last = &k_q[IDX_W-1:0];
    assign last     = &k_q;

    // First entry of a row compares against all-ones so it is always taken.
    assign min_base = (k_q[IDX_W-1:0] == '0) ? '1 : cur_min_q;
    assign new_min  = cost_min(min_base, in_data);

    jam_cost_mem u_mem (
        .CLK   (CLK),
        .we    (we),
        .waddr (k_q),
        .wdata (in_data),
        .raddr ({W, J}),
        .rdata (rdata)
    );

    assign Cost        = table_ready_q ? rdata : '0;
    assign table_ready = table_ready_q;
    assign jam_rst     = jam_rst_q;
    assign row_min_sum = row_min_sum_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= LOAD;
            k_q           <= '0;
            cur_min_q     <= '1;
            acc_q         <= '0;
            row_min_sum_q <= '0;
            table_ready_q <= 1'b0;
            jam_rst_q     <= 1'b1;
        end else if (reload) begin
            // Reload beats a simultaneous accept; the entry is dropped.
            state_q       <= LOAD;
            k_q           <= '0;
            acc_q         <= '0;
            row_min_sum_q <= '0;
            table_ready_q <= 1'b0;
            jam_rst_q     <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        cur_min_q <= new_min;
                        if (row_last) begin
                            acc_q <= acc_q + SUM_W'(new_min);
                        end
                        if (last) begin
                            state_q <= DONE;
                        end else begin
                            k_q <= k_q + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    row_min_sum_q <= acc_q;
                    table_ready_q <= 1'b1;
                    jam_rst_q     <= 1'b0;
                    state_q       <= READY;
                end
                READY: ;
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule
